// File: rtl/mem_mon_pkg.sv
// Shared definitions for the memory-usage peak monitor: read FSM encoding,
// default widths and an unsigned max helper.
package mem_mon_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_CW = 24;

    // Widest usage word the max helper accepts; narrower words are zero-extended.
    localparam int MAX_W  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_t;

    // Unsigned maximum; callers zero-extend W-bit operands to MAX_W.
    function automatic logic [MAX_W-1:0] umax(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_peak_chan.sv
// One monitored channel: sticky peak, tumbling-window peak, saturating
// over-threshold cycle count and registered over-threshold alarm.
module mem_peak_chan
    import mem_mon_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  usage,
    input  logic [W-1:0]  thresh,
    input  logic          win_term,
    input  logic          win_en,
    input  logic          clr,
    output logic [W-1:0]  peak,
    output logic [W-1:0]  win_peak,
    output logic [CW-1:0] over_cnt,
    output logic          alarm
);

    logic [W-1:0] run;
    logic [W-1:0] peak_max;
    logic [W-1:0] run_max;
    logic         over;

    assign over     = (usage > thresh);
    assign peak_max = W'(umax(MAX_W'(peak), MAX_W'(usage)));
    assign run_max  = W'(umax(MAX_W'(run), MAX_W'(usage)));

    // Peak and over-count: clear-on-read restarts from this cycle's sample.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments on all state, so every register in
        // this block sees the pre-edge values of the others.
        if (reset) begin
            peak     <= '0;
            over_cnt <= '0;
            alarm    <= 1'b0;
        end else begin
            alarm <= over;
            if (clr) begin
                peak     <= usage;
                over_cnt <= over ? CW'(1) : '0;
            end else begin
                peak <= peak_max;
                if (over && (over_cnt != '1))
                    over_cnt <= over_cnt + 1'b1;
            end
        end
    end

    // Window maximum: fold samples into run, publish it on the terminal cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= '0;
            win_peak <= '0;
        end else if (win_en) begin
            if (win_term) begin
                win_peak <= run_max;
                run      <= '0;
            end else begin
                run <= run_max;
            end
        end
    end

endmodule

// File: rtl/mem_peak_monitor.sv
// Multi-channel memory-usage peak monitor with a shared tumbling window
// counter and a request/acknowledge read port with optional clear-on-read.
module mem_peak_monitor
    import mem_mon_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = DEF_W,
    parameter int CW  = DEF_CW,
    parameter int CHW = 4
)(
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH*W-1:0] usage_in,
    input  logic [CW-1:0]  window_len,
    input  logic [W-1:0]   thresh,
    input  logic           rd_req,
    input  logic [CHW-1:0] rd_ch,
    input  logic           rd_clr,
    output logic           rd_ack,
    output logic [W-1:0]   rd_peak,
    output logic [W-1:0]   rd_win_peak,
    output logic [CW-1:0]  rd_over_cnt,
    output logic [NCH-1:0] alarm
);

    logic [CW-1:0] wc;
    logic          win_en;
    logic          win_term;
    rd_state_t     state;
    rd_state_t     state_next;
    logic          accept;

    logic [W-1:0]  peak_a     [NCH];
    logic [W-1:0]  win_peak_a [NCH];
    logic [CW-1:0] over_cnt_a [NCH];

    logic [W-1:0]  sel_peak;
    logic [W-1:0]  sel_win_peak;
    logic [CW-1:0] sel_over_cnt;

    // A shrunk window_len makes the current cycle terminal immediately.
    assign win_en   = (window_len != '0);
    assign win_term = win_en && (wc >= window_len - 1'b1);

    // Window counter: 0..window_len-1, parked at 0 while windowing is off.
    always_ff @(posedge clk) begin
        if (reset || win_term || !win_en)
            wc <= '0;
        else
            wc <= wc + 1'b1;
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Read FSM next state: accept a request only in IDLE, spend one cycle in RESP.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_req) begin
                    accept     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign rd_ack = (state == ST_RESP);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        mem_peak_chan #(.W(W), .CW(CW)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .usage    (usage_in[gi*W +: W]),
            .thresh   (thresh),
            .win_term (win_term),
            .win_en   (win_en),
            .clr      (accept && rd_clr && (rd_ch == CHW'(gi))),
            .peak     (peak_a[gi]),
            .win_peak (win_peak_a[gi]),
            .over_cnt (over_cnt_a[gi]),
            .alarm    (alarm[gi])
        );
    end

    // Channel select mux; an unpopulated channel number reads as zero.
    always_comb begin
        sel_peak     = '0;
        sel_win_peak = '0;
        sel_over_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                sel_peak     = peak_a[i];
                sel_win_peak = win_peak_a[i];
                sel_over_cnt = over_cnt_a[i];
            end
        end
    end

    // Read data registers: load on acceptance, hold until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_peak     <= '0;
            rd_win_peak <= '0;
            rd_over_cnt <= '0;
        end else if (accept) begin
            rd_peak     <= sel_peak;
            rd_win_peak <= sel_win_peak;
            rd_over_cnt <= sel_over_cnt;
        end
    end

endmodule

// File: tb/tb_mem_peak_monitor.sv
// Bench for mem_peak_monitor: directed scenarios with hand-derived values,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_mem_peak_monitor;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int CW  = 24;
    localparam int CHW = 4;
    localparam int OVMAX  = (1 << CW) - 1;
    localparam int OVMAX4 = 15;

    logic             clk;
    logic             reset;
    logic [NCH*W-1:0] usage_in;
    logic [CW-1:0]    window_len;
    logic [W-1:0]     thresh;
    logic             rd_req;
    logic [CHW-1:0]   rd_ch;
    logic             rd_clr;
    logic             rd_ack;
    logic [W-1:0]     rd_peak;
    logic [W-1:0]     rd_win_peak;
    logic [CW-1:0]    rd_over_cnt;
    logic [NCH-1:0]   alarm;

    logic [3:0]       window_len4;
    logic             rd4_req;
    logic [CHW-1:0]   rd4_ch;
    logic             rd4_clr;
    logic             rd4_ack;
    logic [W-1:0]     rd4_peak;
    logic [W-1:0]     rd4_win_peak;
    logic [3:0]       rd4_over_cnt;
    logic [NCH-1:0]   alarm4;

    int n_tests = 0;
    int n_fail  = 0;

    mem_peak_monitor #(.NCH(NCH), .W(W), .CW(CW), .CHW(CHW)) dut (
        .clk(clk), .reset(reset), .usage_in(usage_in), .window_len(window_len),
        .thresh(thresh), .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr),
        .rd_ack(rd_ack), .rd_peak(rd_peak), .rd_win_peak(rd_win_peak),
        .rd_over_cnt(rd_over_cnt), .alarm(alarm)
    );

    // Narrow-counter build used to observe over-count saturation.
    mem_peak_monitor #(.NCH(NCH), .W(W), .CW(4), .CHW(CHW)) dut4 (
        .clk(clk), .reset(reset), .usage_in(usage_in), .window_len(window_len4),
        .thresh(thresh), .rd_req(rd4_req), .rd_ch(rd4_ch), .rd_clr(rd4_clr),
        .rd_ack(rd4_ack), .rd_peak(rd4_peak), .rd_win_peak(rd4_win_peak),
        .rd_over_cnt(rd4_over_cnt), .alarm(alarm4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_peak [NCH];
    int m_run  [NCH];
    int m_win  [NCH];
    int m_over [NCH];
    int m_over4[NCH];
    bit m_alarm[NCH];
    int m_wc;
    bit m_busy, m4_busy;
    int e_peak, e_win, e_over, e4_over;

    function automatic int usage_of(input int i);
        return int'(usage_in[i*W +: W]);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        int  u;
        bit  ov, acc, acc4, term;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_peak[i] = 0; m_run[i] = 0; m_win[i] = 0;
                m_over[i] = 0; m_over4[i] = 0; m_alarm[i] = 0;
            end
            m_wc = 0; m_busy = 0; m4_busy = 0;
            e_peak = 0; e_win = 0; e_over = 0; e4_over = 0;
            return;
        end
        acc = rd_req && !m_busy;
        if (acc) begin
            if (int'(rd_ch) < NCH) begin
                e_peak = m_peak[rd_ch]; e_win = m_win[rd_ch]; e_over = m_over[rd_ch];
            end else begin
                e_peak = 0; e_win = 0; e_over = 0;
            end
        end
        m_busy = acc;
        acc4 = rd4_req && !m4_busy;
        if (acc4) e4_over = (int'(rd4_ch) < NCH) ? m_over4[rd4_ch] : 0;
        m4_busy = acc4;
        term = (window_len != 0) && (m_wc >= int'(window_len) - 1);
        for (int i = 0; i < NCH; i++) begin
            u  = usage_of(i);
            ov = (u > int'(thresh));
            if (acc && rd_clr && int'(rd_ch) == i) begin
                m_peak[i] = u;
                m_over[i] = ov ? 1 : 0;
            end else begin
                m_peak[i] = imax(m_peak[i], u);
                if (ov && m_over[i] < OVMAX) m_over[i]++;
            end
            if (ov && m_over4[i] < OVMAX4) m_over4[i]++;
            m_alarm[i] = ov;
            if (window_len != 0) begin
                m_run[i] = imax(m_run[i], u);
                if (term) begin
                    m_win[i] = m_run[i];
                    m_run[i] = 0;
                end
            end
        end
        m_wc = (window_len == 0 || term) ? 0 : m_wc + 1;
    endtask

    // One clock: edge, model step, then settle to the sampling point.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_usage(input int ch, input int v);
        usage_in[ch*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Drive a one-cycle request; returns at the sampling point of the RESP cycle.
    task automatic issue_read(input int ch, input bit clr);
        rd_ch  = CHW'(ch);
        rd_clr = clr;
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        rd_clr = 1'b0;
    endtask

    task automatic test_reset();
        usage_in = '0; thresh = '1; window_len = '0;
        reset = 1'b1;
        cyc(); cyc();
        n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", rd_ack); end
        n_tests++; if (rd_peak !== '0) begin n_fail++; $display("FAIL reset_peak: got %0d expected 0", rd_peak); end
        n_tests++; if (rd_win_peak !== '0) begin n_fail++; $display("FAIL reset_win: got %0d expected 0", rd_win_peak); end
        n_tests++; if (rd_over_cnt !== '0) begin n_fail++; $display("FAIL reset_over: got %0d expected 0", rd_over_cnt); end
        n_tests++; if (alarm !== '0) begin n_fail++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
        reset = 1'b0;
    endtask

    task automatic test_sticky_peak();
        usage_in = '0; thresh = '1; window_len = '0;
        do_reset();
        set_usage(0, 5); cyc();
        set_usage(0, 9); cyc();
        set_usage(0, 3); cyc();
        issue_read(0, 1'b0);
        n_tests++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL peak_ack: got %b expected 1", rd_ack); end
        n_tests++; if (rd_peak !== 16'd9) begin n_fail++; $display("FAIL peak_ramp: got %0d expected 9", rd_peak); end
        cyc();
        n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL peak_ack_width: got %b expected 0", rd_ack); end
        set_usage(0, 12); cyc();
        issue_read(0, 1'b0);
        n_tests++; if (rd_peak !== 16'd12) begin n_fail++; $display("FAIL peak_rise: got %0d expected 12", rd_peak); end
        cyc();
    endtask

    task automatic test_window();
        int s[4] = '{2, 7, 1, 4};
        usage_in = '0; thresh = '1; window_len = CW'(4);
        do_reset();
        for (int i = 0; i < 4; i++) begin set_usage(1, s[i]); cyc(); end
        set_usage(1, 3);
        issue_read(1, 1'b0);
        n_tests++; if (rd_win_peak !== 16'd7) begin n_fail++; $display("FAIL win_first: got %0d expected 7", rd_win_peak); end
        repeat (3) cyc();
        issue_read(1, 1'b0);
        n_tests++; if (rd_win_peak !== 16'd3) begin n_fail++; $display("FAIL win_second: got %0d expected 3", rd_win_peak); end
        cyc();
        window_len = '0;
        set_usage(1, 15);
        repeat (5) cyc();
        issue_read(1, 1'b0);
        n_tests++; if (rd_win_peak !== 16'd3) begin n_fail++; $display("FAIL win_frozen: got %0d expected 3", rd_win_peak); end
        cyc();
    endtask

    task automatic test_over_count();
        int hi = 0;
        usage_in = '0; thresh = W'(10); window_len = '0;
        do_reset();
        n_tests++; if (alarm[2] !== 1'b0) begin n_fail++; $display("FAIL alarm_pre: got %b expected 0", alarm[2]); end
        for (int i = 0; i < 10; i++) begin
            set_usage(2, (i < 6) ? 11 : 10);
            cyc();
            if (alarm[2] === 1'b1) hi++;
        end
        n_tests++; if (hi != 6) begin n_fail++; $display("FAIL alarm_cycles: got %0d expected 6", hi); end
        issue_read(2, 1'b0);
        n_tests++; if (rd_over_cnt !== 24'd6) begin n_fail++; $display("FAIL over_cnt: got %0d expected 6", rd_over_cnt); end
        cyc();
    endtask

    task automatic test_saturation();
        usage_in = '0; thresh = W'(10); window_len = '0;
        do_reset();
        set_usage(3, 200);
        repeat (20) cyc();
        rd_ch = CHW'(3); rd_req = 1'b1;
        rd4_ch = CHW'(3); rd4_req = 1'b1;
        cyc();
        rd_req = 1'b0; rd4_req = 1'b0;
        n_tests++; if (rd4_ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack: got %b expected 1", rd4_ack); end
        n_tests++; if (rd4_over_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", rd4_over_cnt); end
        n_tests++; if (rd_over_cnt !== 24'd20) begin n_fail++; $display("FAIL wide_cnt: got %0d expected 20", rd_over_cnt); end
        repeat (5) cyc();
        rd4_req = 1'b1; cyc(); rd4_req = 1'b0;
        n_tests++; if (rd4_over_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_nowrap: got %0d expected 15", rd4_over_cnt); end
        cyc();
    endtask

    task automatic test_clear_on_read();
        usage_in = '0; thresh = W'(6); window_len = '0;
        set_usage(1, 8);
        do_reset();
        set_usage(0, 5); cyc();
        set_usage(0, 9); cyc();
        set_usage(0, 4);
        issue_read(0, 1'b1);
        n_tests++; if (rd_peak !== 16'd9) begin n_fail++; $display("FAIL clr_old_peak: got %0d expected 9", rd_peak); end
        n_tests++; if (rd_over_cnt !== 24'd1) begin n_fail++; $display("FAIL clr_old_over: got %0d expected 1", rd_over_cnt); end
        cyc();
        issue_read(0, 1'b0);
        n_tests++; if (rd_peak !== 16'd4) begin n_fail++; $display("FAIL clr_new_peak: got %0d expected 4", rd_peak); end
        n_tests++; if (rd_over_cnt !== 24'd0) begin n_fail++; $display("FAIL clr_new_over: got %0d expected 0", rd_over_cnt); end
        cyc();
        issue_read(1, 1'b0);
        n_tests++; if (rd_peak !== 16'd8) begin n_fail++; $display("FAIL clr_other_peak: got %0d expected 8", rd_peak); end
        n_tests++; if (rd_over_cnt !== 24'd6) begin n_fail++; $display("FAIL clr_other_over: got %0d expected 6", rd_over_cnt); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        usage_in = '0; thresh = '1; window_len = '0;
        do_reset();
        set_usage(0, 20); cyc();
        rd_ch = '0; rd_clr = 1'b0; rd_req = 1'b1;
        cyc();
        n_tests++; if (rd_peak !== 16'd20) begin n_fail++; $display("FAIL b2b_peak: got %0d expected 20", rd_peak); end
        if (rd_ack === 1'b1) acks++;
        cyc(); if (rd_ack === 1'b1) acks++;
        rd_req = 1'b0;
        cyc(); if (rd_ack === 1'b1) acks++;
        cyc(); if (rd_ack === 1'b1) acks++;
        n_tests++; if (acks != 1) begin n_fail++; $display("FAIL b2b_acks: got %0d expected 1", acks); end
        set_usage(0, 3);
        issue_read(NCH, 1'b1);
        n_tests++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL oor_ack: got %b expected 1", rd_ack); end
        n_tests++; if ({rd_peak, rd_win_peak, rd_over_cnt} !== '0) begin n_fail++; $display("FAIL oor_data: got %0d/%0d/%0d expected 0/0/0", rd_peak, rd_win_peak, rd_over_cnt); end
        cyc();
        issue_read(0, 1'b0);
        n_tests++; if (rd_peak !== 16'd20) begin n_fail++; $display("FAIL oor_noclear: got %0d expected 20", rd_peak); end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        usage_in = '0; thresh = W'(10); window_len = '0;
        do_reset();
        set_usage(0, 30); cyc();
        issue_read(0, 1'b0);
        n_tests++; if (rd_peak !== 16'd30) begin n_fail++; $display("FAIL mid_pre_peak: got %0d expected 30", rd_peak); end
        reset = 1'b1;
        cyc();
        n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack: got %b expected 0", rd_ack); end
        n_tests++; if ({rd_peak, rd_win_peak, rd_over_cnt, alarm} !== '0) begin n_fail++; $display("FAIL mid_zero: got %0d/%0d/%0d/%b expected all 0", rd_peak, rd_win_peak, rd_over_cnt, alarm); end
        rd_ch = '0; rd_req = 1'b1;
        cyc();
        reset = 1'b0; rd_req = 1'b0;
        n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_req_ack: got %b expected 0", rd_ack); end
        cyc();
        n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_req_late_ack: got %b expected 0", rd_ack); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] exp_al;
        int             printed = 0;
        bit             bad;
        usage_in = '0; thresh = W'(20); window_len = CW'(3);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++)
                set_usage(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 40)));
            if ($urandom_range(0, 49) == 0) thresh = W'($urandom_range(0, 40));
            if ($urandom_range(0, 39) == 0) window_len = CW'($urandom_range(0, 6));
            rd_req = ($urandom_range(0, 2) == 0);
            rd_ch  = CHW'($urandom_range(0, NCH));
            rd_clr = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            cyc();
            for (int i = 0; i < NCH; i++) exp_al[i] = m_alarm[i];
            bad = (rd_ack !== m_busy) || (rd_peak !== W'(e_peak)) || (rd_win_peak !== W'(e_win))
                  || (rd_over_cnt !== CW'(e_over)) || (alarm !== exp_al);
            n_tests++;
            if (bad) begin
                n_fail++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL random cycle %0d: got ack=%b peak=%0d win=%0d over=%0d alarm=%b expected ack=%b peak=%0d win=%0d over=%0d alarm=%b",
                             c, rd_ack, rd_peak, rd_win_peak, rd_over_cnt, alarm,
                             m_busy, e_peak, e_win, e_over, exp_al);
                end
            end
        end
        rd_req = 1'b0; rd_clr = 1'b0; reset = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; usage_in = '0; window_len = '0; thresh = '1;
        rd_req = 1'b0; rd_ch = '0; rd_clr = 1'b0;
        window_len4 = '0; rd4_req = 1'b0; rd4_ch = '0; rd4_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_sticky_peak();
        test_window();
        test_over_count();
        test_saturation();
        test_clear_on_read();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_peak_monitor.md
Name: mem_peak_monitor

Overview:
- Multi-channel successor to the single-channel memory-usage high-water-mark tracker.
- Per-channel outputs:
  - sticky peak;
  - peak over a programmable sliding-free (tumbling) window;
  - saturating count of cycles spent above a programmable threshold;
  - live over-threshold alarm.
- Sits beside the SFP/readout FIFOs; slow-control logic reads one channel at a time through a request/acknowledge port with optional clear-on-read.

Parameters:
- NCH, 4, number of monitored channels (1..16)
- W, 16, usage word width in bits
- CW, 24, width of window length and over-threshold counters
- CHW, 4, width of channel select (≥ clog2(NCH), min 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- usage_in  in  NCH*W  current usage; channel i occupies bits [i*W +: W]; sampled every cycle
- window_len  in  CW  window length in cycles; 0 disables windowing
- thresh  in  W  over-threshold level, shared by all channels
- rd_req  in  1  read request pulse
- rd_ch  in  CHW  channel to read, sampled with rd_req
- rd_clr  in  1  clear peak and over-count of rd_ch after read, sampled with rd_req
- rd_ack  out  1  one-cycle pulse: rd_* data valid
- rd_peak  out  W  sticky peak of the selected channel
- rd_win_peak  out  W  last completed-window peak of the selected channel
- rd_over_cnt  out  CW  over-threshold cycle count of the selected channel
- alarm  out  NCH  registered, bit i = (usage_i > thresh)

Behaviour:
- Reset (synchronous, dominant over all other activity):
  - All peaks, window peaks, running window maxima, over-counts, window counter, alarm, rd_ack and rd_* outputs go to 0.
  - FSM goes to IDLE.
- Sticky peak:
  - peak_i <= max(peak_i, usage_i) each cycle, unsigned compare.
  - Value is visible one cycle after the sample.
- Window logic:
  - Counter wc counts 0..window_len-1.
  - At wc == window_len-1 (terminal cycle):
    - win_peak_i <= max(run_i, usage_i);
    - run_i <= 0;
    - wc <= 0.
  - Otherwise run_i <= max(run_i, usage_i) and wc increments.
  - window_len == 0: wc held at 0, run_i and win_peak_i hold their values.
  - window_len == 1: win_peak_i tracks usage_i with 1-cycle latency.
  - window_len changed mid-window: if wc ≥ new window_len-1, the current cycle is treated as terminal.
- Over-count:
  - over_cnt_i increments when usage_i > thresh (strict).
  - Saturates at 2^CW-1 and never wraps.
  - alarm_i <= (usage_i > thresh), 1-cycle latency.
- Read FSM, states IDLE and RESP:
  - IDLE: when rd_req=1, latch rd_ch/rd_clr, load rd_peak/rd_win_peak/rd_over_cnt from that channel's registers as of that cycle, go to RESP.
  - RESP: rd_ack=1 for exactly one cycle, then return to IDLE. rd_req seen in RESP is ignored, with no ack.
  - Back-to-back reads: minimum spacing of 2 cycles.
  - rd_* outputs hold their values until the next accepted read.
- Clear-on-read:
  - Takes effect at the same edge that moves the FSM to RESP.
  - peak_ch <= usage_ch of that cycle (clear-then-update, so no sample is lost).
  - over_cnt_ch <= (usage_ch > thresh) ? 1 : 0.
  - win_peak, run and the window counter are unaffected.
- rd_ch ≥ NCH: read is accepted and rd_ack pulses, but all rd_* data = 0 and no clear occurs.
- Reset mid-read: rd_ack is suppressed, FSM returns to IDLE.

Decomposition:
- Shared package mem_mon_pkg holds:
  - FSM state encoding (ST_IDLE, ST_RESP);
  - default W/CW constants;
  - a max function for unsigned W-bit operands.
- Sub-module mem_peak_chan, one instance per channel, holds peak, run, win_peak, over_cnt and alarm.
  - Inputs: usage, thresh, window-terminal strobe, window-enable, clear strobe.
- The top level holds the window counter, the read FSM and the output mux.

Test Plan:
- Reset then ramp ch0 through 5, 9, 3: rd_req ch0 → rd_ack next cycle, rd_peak = 9. Then drive 12 → re-read gives 12.
- window_len = 4, ch1 samples 2, 7, 1, 4 | 3, 3, 3, 3: rd_win_peak = 7 after the first window, 3 after the second. window_len = 0 → value frozen.
- thresh = 10, ch2 = 11 for 6 cycles then 10 → rd_over_cnt = 6, alarm[2] high for exactly 6 cycles (delayed by 1).
- CW = 4 build, ch3 held above thresh for 20 cycles → rd_over_cnt = 15, no wrap.
- rd_clr on ch0 with peak = 9 while usage = 4 → rd_peak = 9 returned, subsequent read returns 4. Other channels unchanged.
- rd_req on consecutive cycles → only one rd_ack. rd_ch = NCH → ack with zero data. Reset asserted in RESP → no ack, all outputs 0.
